// File: rtl/regfile_mp.sv
// Multi-port register file with write-first bypass, busy scoreboard and sequenced clear.
// Latency: reads are combinational (0 cycles); writes, reservations and clear steps land on posedge.
// Backpressure: ready drops for the 2**AW-1 cycle clear sweep; writes, reservations and clr_req are dropped meanwhile.
module regfile_mp #(
    parameter int              DW      = 32,
    parameter int              AW      = 5,
    parameter int              NRD     = 3,
    parameter int              NWR     = 2,
    parameter int              SP_IDX  = 29,
    parameter logic [DW-1:0]   SP_INIT = 32'h100
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*DW-1:0]   rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*DW-1:0]   wr_data,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    input  logic                clr_req,
    output logic                ready
);

    localparam int            DEPTH = 2**AW;
    localparam logic [AW-1:0] SP_A  = AW'(SP_IDX);
    localparam logic [AW-1:0] LAST  = '1;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t              state, state_nxt;
    logic                sweep_start;
    logic [AW-1:0]       ptr;
    logic [DW-1:0]       regs [DEPTH];
    logic [DEPTH-1:0]    busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        sweep_start = 1'b0;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt   = SWEEP;
                    sweep_start = 1'b1;
                end
            end
            SWEEP: begin
                if (ptr == LAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ready = (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                             ptr <= AW'(1);
        else if (sweep_start)                ptr <= AW'(1);
        else if (state == SWEEP)             ptr <= (ptr == LAST) ? AW'(1) : ptr + AW'(1);
    end

    // Ports are walked in ascending order so the highest-index same-address write lands last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < DEPTH; j++)
                regs[j] <= (j == SP_IDX) ? SP_INIT : '0;
        end else if (state == SWEEP) begin
            regs[ptr] <= (ptr == SP_A) ? SP_INIT : '0;
        end else begin
            for (int k = 0; k < NWR; k++)
                if (wr_en[k] && (wr_addr[k*AW +: AW] != '0))
                    regs[wr_addr[k*AW +: AW]] <= wr_data[k*DW +: DW];
        end
    end

    // A reservation in the same cycle as a write wins: it names the newer producer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else if (state == IDLE) begin
            if (clr_req) begin
                busy <= '0;
            end else begin
                for (int k = 0; k < NWR; k++)
                    if (wr_en[k] && (wr_addr[k*AW +: AW] != '0))
                        busy[wr_addr[k*AW +: AW]] <= 1'b0;
                if (rsv_en && (rsv_addr != '0))
                    busy[rsv_addr] <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          byp;
        logic          rsvh;

        assign a = rd_addr[i*AW +: AW];

        always_comb begin
            d    = regs[a];
            byp  = 1'b0;
            rsvh = 1'b0;
            if (state == IDLE) begin
                for (int k = 0; k < NWR; k++) begin
                    if (wr_en[k] && (wr_addr[k*AW +: AW] == a)) begin
                        d   = wr_data[k*DW +: DW];
                        byp = 1'b1;
                    end
                end
                rsvh = rsv_en && (rsv_addr == a);
            end
        end

        assign rd_data[i*DW +: DW] = (a == '0) ? '0 : d;
        assign rd_busy[i] = (a != '0) && (state == IDLE) && busy[a] && !(byp && !rsvh);
    end

endmodule
